// File: rtl/grant_latch.sv
// Grant holding register: captures a one-hot grant, holds it until release (or timeout
// when GRANT_LATCH_TIMEOUT_EN is defined), then forces a dead gap before the next capture.
module grant_latch #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned GAP_CYCLES = 1,
  localparam int unsigned IdxW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] in,
  input  logic             release_req,
  output logic [WIDTH-1:0] out,
  output logic [IdxW-1:0]  owner_idx,
  output logic             ready,
  output logic             busy,
  output logic             expired,
  output logic             onehot_err
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("grant_latch: WIDTH must be >= 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("grant_latch: MAX_HOLD must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              leave;

`ifdef GRANT_LATCH_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              expired_q, expired_d;
`endif

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  logic cand_multi;
  assign cand_multi = |(in & (in - WIDTH'(1)));

  function automatic logic [IdxW-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = idx | IdxW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    leave   = 1'b0;
`ifdef GRANT_LATCH_TIMEOUT_EN
    hold_d    = hold_q;
    expired_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (load && ack) begin
          if (cand_multi) begin
            err_d = 1'b1;
          end else if (in != '0) begin
            out_d   = in;
            idx_d   = onehot_to_idx(in);
            state_d = StGrant;
`ifdef GRANT_LATCH_TIMEOUT_EN
            hold_d  = HoldW'(1);
`endif
          end
        end
      end

      StGrant: begin
        // Release wins over a simultaneous expiry, so expired stays low then.
        if (release_req) begin
          out_d = '0;
          leave = 1'b1;
`ifdef GRANT_LATCH_TIMEOUT_EN
        end else if (hold_q == HoldW'(MAX_HOLD)) begin
          out_d     = '0;
          expired_d = 1'b1;
          leave     = 1'b1;
        end else begin
          hold_d = hold_q + HoldW'(1);
`endif
        end

        if (leave) begin
`ifdef GRANT_LATCH_TIMEOUT_EN
          hold_d = '0;
`endif
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            gap_d   = GapW'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end

      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES)) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef GRANT_LATCH_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;
`else
  assign expired = 1'b0;
`endif

  assign out        = out_q;
  assign owner_idx  = idx_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign onehot_err = err_q;

endmodule
